// File: rtl/axis_pkg.sv
// Shared types and width helpers for the AXI-Stream FIFO family.
package axis_pkg;

  typedef enum logic {
    STORE = 1'b0,
    FLUSH = 1'b1
  } pfifo_state_t;

  // Pointer width: address bits plus one wrap flag.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width able to hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, combinational read.
module axis_fifo_ram #(
  parameter int W     = 37,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with cut-through or store-and-forward delivery, plus a
// flush fallback so packets longer than the buffer cannot deadlock it.
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int BUS_W       = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 1,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int CW             = cnt_w(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  s_data,
  input  logic [WORDS_PER_BEAT-1:0]              s_keep,
  input  logic                                   s_last,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  m_data,
  output logic [WORDS_PER_BEAT-1:0]              m_keep,
  output logic                                   m_last,
  output logic [CW-1:0]                          count,
  output logic [CW-1:0]                          pkt_count,
  output pfifo_state_t                           state
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef struct packed {
    logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data;
    logic [WORDS_PER_BEAT-1:0]             keep;
    logic                                  last;
  } beat_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          out_of_reset, full, empty, push, pop;
  logic [CW-1:0] count_nxt, pkt_count_nxt;
  pfifo_state_t  state_nxt;
  beat_t         wr_beat, rd_beat;

  // Handshake: a beat moves on a port only in a cycle where valid and ready
  // are both high; m_valid, once high, holds until the beat is taken.
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign s_ready = out_of_reset && !full;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_comb begin
    if (PACKET_MODE == 0 || state == FLUSH) m_valid = !empty;
    else                                    m_valid = !empty && (pkt_count != '0);
  end

  assign wr_beat = {s_data, s_keep, s_last};
  assign m_data  = rd_beat.data;
  assign m_keep  = rd_beat.keep;
  assign m_last  = rd_beat.last;

  axis_fifo_ram #(
    .W     ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_beat),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_beat)
  );

  always_comb begin
    count_nxt     = count;
    pkt_count_nxt = pkt_count;
    state_nxt     = state;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (pop && !push) count_nxt = count - CNT_ONE;
    if ((push && s_last) && !(pop && m_last))      pkt_count_nxt = pkt_count + CNT_ONE;
    else if ((pop && m_last) && !(push && s_last)) pkt_count_nxt = pkt_count - CNT_ONE;
    // Full with no complete packet means the head packet can never finish
    // buffering, so release it in cut-through until its last beat leaves.
    if (PACKET_MODE != 0) begin
      if (state == STORE) begin
        if (count_nxt == FULL_CNT && pkt_count_nxt == '0) state_nxt = FLUSH;
      end else if (pop && m_last) begin
        state_nxt = STORE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_of_reset <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pkt_count    <= '0;
      state        <= STORE;
    end else begin
      out_of_reset <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_nxt;
      pkt_count <= pkt_count_nxt;
      state     <= state_nxt;
    end
  end

endmodule
